// File: rtl/alu_exec_unit.sv
// ALU execute stage: operand read, compute, and a small result FIFO that rides out CDB arbitration loss.
// Optional `ALU_BYPASS_EN forwards the granted CDB head into same-cycle operands.
module alu_exec_unit #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         exception_sig,
    input  logic         mret_sig,
    input  logic [126:0] issue_pkt,
    output logic         alu_stall,
    output logic [7:0]   rf_raddr1,
    output logic [7:0]   rf_raddr2,
    input  logic [31:0]  rf_rdata1,
    input  logic [31:0]  rf_rdata2,
    input  logic         cdb_grant,
    output logic         ALU_result_valid,
    output logic [7:0]   ALU_result_dest,
    output logic [31:0]  ALU_result_data,
    output logic [31:0]  ALU_result_inst_num,
    output logic [31:0]  ALU_result_PC,
    output logic         overflow_err
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [7:0]  dest;
        logic [31:0] data;
        logic [31:0] inst_num;
        logic [31:0] pc;
    } entry_t;

    logic        s1_valid, s1_src1, s1_src2;
    logic [7:0]  s1_op1, s1_op2, s1_rd;
    logic [31:0] s1_inst, s1_pc, s1_imm;
    logic [3:0]  s1_aluop;

    logic          flush, fifo_valid, full, push, pop;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    entry_t        fifo [FIFO_DEPTH];
    entry_t        head;
    logic [31:0]   op_a, op_b, result;

    assign flush = exception_sig | mret_sig;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_op1   <= '0;
            s1_op2   <= '0;
            s1_inst  <= '0;
            s1_pc    <= '0;
            s1_rd    <= '0;
            s1_aluop <= '0;
            s1_src1  <= 1'b0;
            s1_src2  <= 1'b0;
            s1_imm   <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= issue_pkt[78];
            if (issue_pkt[78]) begin
                s1_op2   <= issue_pkt[126:119];
                s1_op1   <= issue_pkt[118:111];
                s1_inst  <= issue_pkt[110:79];
                s1_pc    <= issue_pkt[77:46];
                s1_rd    <= issue_pkt[45:38];
                s1_aluop <= issue_pkt[37:34];
                s1_src1  <= issue_pkt[33];
                s1_src2  <= issue_pkt[32];
                s1_imm   <= issue_pkt[31:0];
            end
        end
    end

    assign rf_raddr1 = s1_op1;
    assign rf_raddr2 = s1_op2;

    assign head       = fifo[rd_ptr];
    assign fifo_valid = (count != '0);
    assign full       = (count == CW'(FIFO_DEPTH));
    assign pop        = fifo_valid && cdb_grant;
    // A full FIFO still accepts when the head leaves on the same edge.
    assign push       = s1_valid && (!full || pop);

    always_comb begin
        op_a = s1_src1 ? s1_pc  : rf_rdata1;
        op_b = s1_src2 ? s1_imm : rf_rdata2;
`ifdef ALU_BYPASS_EN
        // The register file is written from this same head on this edge, so its read data is stale.
        if (!s1_src1 && pop && head.dest == s1_op1) op_a = head.data;
        if (!s1_src2 && pop && head.dest == s1_op2) op_b = head.data;
`endif
    end

    always_comb begin
        result = '0;
        case (s1_aluop)
            4'd0:    result = op_a + op_b;
            4'd1:    result = op_a - op_b;
            4'd2:    result = op_a << op_b[4:0];
            4'd3:    result = {31'b0, $signed(op_a) < $signed(op_b)};
            4'd4:    result = {31'b0, op_a < op_b};
            4'd5:    result = op_a ^ op_b;
            4'd6:    result = op_a >> op_b[4:0];
            4'd7:    result = $signed(op_a) >>> op_b[4:0];
            4'd8:    result = op_a | op_b;
            4'd9:    result = op_a & op_b;
            4'd10:   result = op_b;
            default: result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset && !flush && push)
            fifo[wr_ptr] <= '{dest: s1_rd, data: result, inst_num: s1_inst, pc: s1_pc};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_err <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (s1_valid && full && !pop) overflow_err <= 1'b1;
        end
    end

    assign alu_stall = ({1'b0, count} + {{CW{1'b0}}, s1_valid}) >= (CW+1)'(FIFO_DEPTH - 1);

    // Gated so an empty FIFO never exposes stale or flushed entries.
    assign ALU_result_valid    = fifo_valid;
    assign ALU_result_dest     = fifo_valid ? head.dest     : '0;
    assign ALU_result_data     = fifo_valid ? head.data     : '0;
    assign ALU_result_inst_num = fifo_valid ? head.inst_num : '0;
    assign ALU_result_PC       = fifo_valid ? head.pc       : '0;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios plus random traffic against a queue model.
module tb_alu_exec_unit;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         reset, exception_sig, mret_sig, cdb_grant;
    logic [126:0] issue_pkt;
    logic         alu_stall, ALU_result_valid, overflow_err;
    logic [7:0]   rf_raddr1, rf_raddr2, ALU_result_dest;
    logic [31:0]  rf_rdata1, rf_rdata2, ALU_result_data, ALU_result_inst_num, ALU_result_PC;

    logic [31:0] rf [256];
    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    always #5 clk = ~clk;

    alu_exec_unit #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .exception_sig(exception_sig), .mret_sig(mret_sig),
        .issue_pkt(issue_pkt), .alu_stall(alu_stall),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .cdb_grant(cdb_grant), .ALU_result_valid(ALU_result_valid),
        .ALU_result_dest(ALU_result_dest), .ALU_result_data(ALU_result_data),
        .ALU_result_inst_num(ALU_result_inst_num), .ALU_result_PC(ALU_result_PC),
        .overflow_err(overflow_err)
    );

    int n_chk = 0, n_fail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [126:0] mk(input logic [7:0] o1, input logic [7:0] o2,
                                        input logic [31:0] inst, input logic [31:0] pc,
                                        input logic [7:0] rd, input logic [3:0] op,
                                        input logic s1, input logic s2, input logic [31:0] imm);
        return {o2, o1, inst, 1'b1, pc, rd, op, s1, s2, imm};
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa = a;
        int sb = b;
        int unsigned sh = b % 32;
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return a << sh;
            3:  return (sa < sb) ? 32'd1 : 32'd0;
            4:  return (a < b) ? 32'd1 : 32'd0;
            5:  return a ^ b;
            6:  return a >> sh;
            7:  return sa >>> sh;
            8:  return a | b;
            9:  return a & b;
            10: return b;
            default: return 32'd0;
        endcase
    endfunction

    // Reference model: one pending stage plus an ordered queue of results.
    typedef struct {
        logic [7:0]  dest;
        logic [31:0] data, inst, pc;
    } res_t;
    res_t         q[$];
    res_t         m_head, m_res;
    logic         m_s1v = 1'b0, m_ovf = 1'b0, m_pop;
    logic [126:0] m_s1 = '0;
    logic [31:0]  m_a, m_b;

    always @(posedge clk) begin
        if (reset) begin
            q.delete(); m_s1v = 1'b0; m_s1 = '0; m_ovf = 1'b0;
        end else if (exception_sig || mret_sig) begin
            q.delete(); m_s1v = 1'b0;
        end else begin
            m_pop = (q.size() > 0) && cdb_grant;
            if (q.size() > 0) m_head = q[0];
            if (m_s1v) begin
                m_a = m_s1[33] ? m_s1[77:46] : rf[m_s1[118:111]];
                m_b = m_s1[32] ? m_s1[31:0]  : rf[m_s1[126:119]];
`ifdef ALU_BYPASS_EN
                if (!m_s1[33] && m_pop && m_head.dest == m_s1[118:111]) m_a = m_head.data;
                if (!m_s1[32] && m_pop && m_head.dest == m_s1[126:119]) m_b = m_head.data;
`endif
                m_res = '{dest: m_s1[45:38], data: ref_alu(m_s1[37:34], m_a, m_b),
                          inst: m_s1[110:79], pc: m_s1[77:46]};
            end
            if (m_pop) void'(q.pop_front());
            if (m_s1v) begin
                if (q.size() < DEPTH) q.push_back(m_res);
                else m_ovf = 1'b1;
            end
            if (issue_pkt[78]) begin m_s1 = issue_pkt; m_s1v = 1'b1; end
            else m_s1v = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_valid", 32'(ALU_result_valid), 32'(q.size() > 0));
            if (q.size() > 0) begin
                check("m_dest", 32'(ALU_result_dest), 32'(q[0].dest));
                check("m_data", ALU_result_data, q[0].data);
                check("m_inst", ALU_result_inst_num, q[0].inst);
                check("m_pc",   ALU_result_PC, q[0].pc);
            end
            check("m_stall", 32'(alu_stall), 32'((q.size() + int'(m_s1v)) >= DEPTH - 1));
            check("m_ovf",   32'(overflow_err), 32'(m_ovf));
            check("m_raddr1", 32'(rf_raddr1), 32'(m_s1[118:111]));
            check("m_raddr2", 32'(rf_raddr2), 32'(m_s1[126:119]));
        end
    end

    task automatic issue(input logic [126:0] p);
        issue_pkt = p;
        @(negedge clk);
        issue_pkt = '0;
    endtask

    logic [3:0]  t_op  [4] = '{4'd7, 4'd3, 4'd4, 4'd12};
    logic [31:0] t_pc  [4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234};
    logic [31:0] t_imm [4] = '{32'd4, 32'd1, 32'd1, 32'd5};
    logic [31:0] t_exp [4] = '{32'hF800_0000, 32'd1, 32'd0, 32'd0};
    logic [31:0] byp_exp;

    initial begin
        reset = 1'b1; exception_sig = 1'b0; mret_sig = 1'b0; cdb_grant = 1'b0; issue_pkt = '0;
        for (int i = 0; i < 256; i++) rf[i] = $urandom;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_valid", 32'(ALU_result_valid), 0);
        check("rst_dest",  32'(ALU_result_dest), 0);
        check("rst_data",  ALU_result_data, 0);
        check("rst_inst",  ALU_result_inst_num, 0);
        check("rst_pc",    ALU_result_PC, 0);
        check("rst_stall", 32'(alu_stall), 0);
        check("rst_raddr", 32'({rf_raddr1, rf_raddr2}), 0);
        check("rst_ovf",   32'(overflow_err), 0);
        reset = 1'b0;

        // ADD 5 + imm 7 with grant held: visible one cycle after the FIFO write, then popped.
        cdb_grant = 1'b1; rf[3] = 32'd5;
        issue(mk(8'd3, 8'd0, 32'd1, 32'h40, 8'h12, 4'd0, 1'b0, 1'b1, 32'd7));
        check("lat_early", 32'(ALU_result_valid), 0);
        @(negedge clk);
        check("lat_valid", 32'(ALU_result_valid), 1);
        check("lat_dest",  32'(ALU_result_dest), 32'h12);
        check("lat_data",  ALU_result_data, 32'd12);
        @(negedge clk);
        check("lat_popped", 32'(ALU_result_valid), 0);

        for (int k = 0; k < 4; k++) begin
            issue(mk(8'd0, 8'd0, 32'(10 + k), t_pc[k], 8'(8'h30 + k), t_op[k], 1'b1, 1'b1, t_imm[k]));
            @(negedge clk);
            check("op_data", ALU_result_data, t_exp[k]);
            @(negedge clk);
        end

        // No grant: stall once count+pending reaches 3; results released in issue order.
        cdb_grant = 1'b0;
        for (int k = 0; k < 4; k++) begin
            issue(mk(8'(k), 8'(k + 1), 32'(100 + k), 32'(k), 8'(k), 4'd0, 1'b0, 1'b0, 32'd0));
            check("stall_ramp", 32'(alu_stall), 32'(k >= 2));
        end
        @(negedge clk);
        check("full_valid", 32'(ALU_result_valid), 1);
        cdb_grant = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("order_inst", ALU_result_inst_num, 32'(100 + k));
            @(negedge clk);
        end
        check("drained", 32'(ALU_result_valid), 0);

        // Overflow: fifth result with no grant is dropped; sticky across flush, cleared by reset.
        cdb_grant = 1'b0;
        for (int k = 0; k < 5; k++)
            issue(mk(8'd1, 8'd2, 32'(200 + k), 32'd0, 8'd5, 4'd5, 1'b0, 1'b0, 32'd0));
        @(negedge clk);
        check("ovf_set",  32'(overflow_err), 1);
        check("ovf_head", ALU_result_inst_num, 32'd200);
        mret_sig = 1'b1;
        @(negedge clk);
        mret_sig = 1'b0;
        check("ovf_hold",  32'(overflow_err), 1);
        check("ovf_flush", 32'(ALU_result_valid), 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("ovf_clr", 32'(overflow_err), 0);

        // Flush with three entries held and a valid packet arriving the same edge.
        for (int k = 0; k < 3; k++)
            issue(mk(8'd4, 8'd5, 32'(300 + k), 32'd0, 8'd6, 4'd9, 1'b0, 1'b0, 32'd0));
        @(negedge clk);
        check("fl_pre", 32'(ALU_result_valid), 1);
        exception_sig = 1'b1;
        issue(mk(8'd4, 8'd5, 32'd399, 32'd0, 8'd6, 4'd0, 1'b0, 1'b0, 32'd0));
        exception_sig = 1'b0;
        check("fl_valid", 32'(ALU_result_valid), 0);
        check("fl_stall", 32'(alu_stall), 0);
        @(negedge clk);
        check("fl_gone", 32'(ALU_result_valid), 0);

        // Head dest 0x20 data 0x55 granted while the next op reads phys 0x20 (rf holds 0).
        rf[8'h20] = 32'd0;
        issue(mk(8'd0, 8'd0, 32'd500, 32'h55, 8'h20, 4'd0, 1'b1, 1'b1, 32'd0));
        issue(mk(8'h20, 8'd0, 32'd501, 32'd0, 8'h21, 4'd0, 1'b0, 1'b1, 32'd0));
        cdb_grant = 1'b1;
        @(negedge clk);
`ifdef ALU_BYPASS_EN
        byp_exp = 32'h55;
`else
        byp_exp = 32'h0;
`endif
        check("byp_dest", 32'(ALU_result_dest), 32'h21);
        check("byp_data", ALU_result_data, byp_exp);
        @(negedge clk);

        for (int c = 0; c < 3000; c++) begin
            cdb_grant     = ($urandom_range(0, 9) < 6);
            exception_sig = ($urandom_range(0, 99) == 0);
            mret_sig      = ($urandom_range(0, 99) == 1);
            reset         = ($urandom_range(0, 999) == 0);
            if (($urandom_range(0, 9) < 7) && (!alu_stall || $urandom_range(0, 9) == 0))
                issue_pkt = mk(8'($urandom), 8'($urandom), $urandom, $urandom, 8'($urandom),
                               4'($urandom), 1'($urandom), 1'($urandom), $urandom);
            else
                issue_pkt = '0;
            if ($urandom_range(0, 3) == 0) rf[$urandom_range(0, 255)] = $urandom;
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
